// File: rtl/parity_mod_pkg.sv
// Shared types and the residue-step arithmetic for the parity/modulus frame checker.
package parity_mod_pkg;

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  // Widest residue supported (MOD <= 255).
  localparam int unsigned MaxRw = 8;

  // One MSB-first step of (2*acc + bit) mod m. Because acc < m, one conditional subtract suffices.
  function automatic logic [MaxRw:0] residue_step(input logic [MaxRw-1:0] acc,
                                                  input logic             bit_in,
                                                  input logic [MaxRw:0]   modulus);
    logic [MaxRw:0] sum;
    sum = {acc, bit_in};
    if (sum >= modulus) sum = sum - modulus;
    return sum;
  endfunction

endpackage

// File: rtl/parity_mod_step.sv
// Combinational residue step: next = (2*acc + bit_in) mod MOD.
module parity_mod_step
  import parity_mod_pkg::*;
#(
  parameter int unsigned MOD = 3,
  localparam int unsigned RW = $clog2(MOD)
) (
  input  logic [RW-1:0] acc,
  input  logic          bit_in,
  output logic [RW-1:0] next_acc
);

  logic [MaxRw:0] wide;
  logic           unused_hi;

  assign wide      = residue_step(MaxRw'(acc), bit_in, (MaxRw + 1)'(MOD));
  assign next_acc  = wide[RW-1:0];
  // Upper bits are always zero after the subtract.
  assign unused_hi = ^wide[MaxRw:RW];

endmodule

// File: rtl/parity_mod_fsm.sv
// Serial frame checker: accumulates FRAME_LEN MSB-first bits, then reports residue mod MOD,
// value parity and ones-count parity with a one-cycle done pulse.
module parity_mod_fsm
  import parity_mod_pkg::*;
#(
  parameter int unsigned MOD       = 3,
  parameter int unsigned FRAME_LEN = 8,
  localparam int unsigned RW       = $clog2(MOD)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          in_valid,
  input  logic          in_bit,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] residue,
  output logic          divisible,
  output logic          even,
  output logic          odd,
  output logic          ones_even
);

  localparam int unsigned CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LastCnt = CW'(FRAME_LEN - 1);

  state_e        state_q, state_d;
  logic [RW-1:0] acc_q, acc_d, acc_step;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          onespar_q, onespar_d;
  logic          lastbit_q, lastbit_d;
  logic [RW-1:0] residue_q, residue_d;
  logic          divisible_q, divisible_d;
  logic          even_q, even_d;
  logic          odd_q, odd_d;
  logic          ones_even_q, ones_even_d;
  logic          clr;

  parity_mod_step #(
    .MOD(MOD)
  ) u_step (
    .acc     (acc_q),
    .bit_in  (in_bit),
    .next_acc(acc_step)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    onespar_d   = onespar_q;
    lastbit_d   = lastbit_q;
    residue_d   = residue_q;
    divisible_d = divisible_q;
    even_d      = even_q;
    odd_d       = odd_q;
    ones_even_d = ones_even_q;
    clr         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StAccum;
          clr     = 1'b1;
        end
      end
      StAccum: begin
        if (abort) begin
          state_d = StIdle;
        end else if (start) begin
          clr = 1'b1;
        end else if (in_valid) begin
          acc_d     = acc_step;
          cnt_d     = cnt_q + CW'(1);
          onespar_d = onespar_q ^ in_bit;
          lastbit_d = in_bit;
          // Results are latched on the same edge that samples the final bit.
          if (cnt_q == LastCnt) begin
            state_d     = StDone;
            residue_d   = acc_d;
            divisible_d = (acc_d == '0);
            even_d      = ~lastbit_d;
            odd_d       = lastbit_d;
            ones_even_d = ~onespar_d;
          end
        end
      end
      StDone: begin
        state_d = start ? StAccum : StIdle;
        clr     = start;
      end
      default: state_d = StIdle;
    endcase

    if (clr) begin
      acc_d     = '0;
      cnt_d     = '0;
      onespar_d = 1'b0;
      lastbit_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      onespar_q   <= 1'b0;
      lastbit_q   <= 1'b0;
      residue_q   <= '0;
      divisible_q <= 1'b0;
      even_q      <= 1'b0;
      odd_q       <= 1'b0;
      ones_even_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      onespar_q   <= onespar_d;
      lastbit_q   <= lastbit_d;
      residue_q   <= residue_d;
      divisible_q <= divisible_d;
      even_q      <= even_d;
      odd_q       <= odd_d;
      ones_even_q <= ones_even_d;
    end
  end

  assign busy      = (state_q == StAccum);
  assign done      = (state_q == StDone);
  assign residue   = residue_q;
  assign divisible = divisible_q;
  assign even      = even_q;
  assign odd       = odd_q;
  assign ones_even = ones_even_q;

endmodule

// File: tb/tb_parity_mod_fsm.sv
// Bench for parity_mod_fsm: three instances (MOD3/8, MOD5/4, MOD2/8) checked against a whole-value
// frame model every cycle, plus directed frames with hand-computed results.
module tb_parity_mod_fsm;

  localparam int N = 3;

  typedef struct {
    logic            busy;
    logic            done;
    longint unsigned val;
    int              cnt;
    logic [7:0]      res;
    logic            dv;
    logic            ev;
    logic            od;
    logic            oe;
  } mstate_t;

  logic clk = 1'b0;
  logic reset;
  logic start [N];
  logic abort [N];
  logic in_valid [N];
  logic in_bit [N];
  logic busy [N];
  logic done [N];
  logic divisible [N];
  logic even [N];
  logic odd [N];
  logic ones_even [N];
  logic [1:0] res0;
  logic [2:0] res1;
  logic [0:0] res2;
  logic [7:0] res [N];

  mstate_t m [N];
  int      n_tests = 0;
  int      n_fail  = 0;
  int      cyc     = 0;
  logic    chk_en  = 1'b0;

  always #5 clk = ~clk;

  parity_mod_fsm #(.MOD(3), .FRAME_LEN(8)) dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .abort(abort[0]), .in_valid(in_valid[0]),
    .in_bit(in_bit[0]), .busy(busy[0]), .done(done[0]), .residue(res0),
    .divisible(divisible[0]), .even(even[0]), .odd(odd[0]), .ones_even(ones_even[0])
  );
  parity_mod_fsm #(.MOD(5), .FRAME_LEN(4)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .abort(abort[1]), .in_valid(in_valid[1]),
    .in_bit(in_bit[1]), .busy(busy[1]), .done(done[1]), .residue(res1),
    .divisible(divisible[1]), .even(even[1]), .odd(odd[1]), .ones_even(ones_even[1])
  );
  parity_mod_fsm #(.MOD(2), .FRAME_LEN(8)) dut2 (
    .clk(clk), .reset(reset), .start(start[2]), .abort(abort[2]), .in_valid(in_valid[2]),
    .in_bit(in_bit[2]), .busy(busy[2]), .done(done[2]), .residue(res2),
    .divisible(divisible[2]), .even(even[2]), .odd(odd[2]), .ones_even(ones_even[2])
  );

  assign res[0] = 8'(res0);
  assign res[1] = 8'(res1);
  assign res[2] = 8'(res2);

  function automatic int mod_of(input int i);
    case (i)
      0:       return 3;
      1:       return 5;
      default: return 2;
    endcase
  endfunction

  function automatic int len_of(input int i);
    return (i == 1) ? 4 : 8;
  endfunction

  function automatic mstate_t zero_state();
    mstate_t z;
    z.busy = 1'b0; z.done = 1'b0; z.val = 0; z.cnt = 0; z.res = 8'd0;
    z.dv = 1'b0; z.ev = 1'b0; z.od = 1'b0; z.oe = 1'b0;
    return z;
  endfunction

  // Frame-level model: keeps the whole received value and derives results with plain arithmetic.
  function automatic mstate_t model_next(input mstate_t s, input int i, input logic st,
                                         input logic ab, input logic v, input logic b);
    mstate_t nx;
    longint unsigned md;
    nx      = s;
    nx.done = 1'b0;
    md      = longint'(mod_of(i));
    if (!s.busy) begin
      if (st) begin
        nx.busy = 1'b1; nx.val = 0; nx.cnt = 0;
      end
    end else if (ab) begin
      nx.busy = 1'b0;
    end else if (st) begin
      nx.val = 0; nx.cnt = 0;
    end else if (v) begin
      nx.val = s.val * 2 + (b ? 1 : 0);
      nx.cnt = s.cnt + 1;
      if (nx.cnt == len_of(i)) begin
        nx.busy = 1'b0;
        nx.done = 1'b1;
        nx.res  = 8'(nx.val % md);
        nx.dv   = (nx.val % md) == 0;
        nx.ev   = (nx.val % 2) == 0;
        nx.od   = (nx.val % 2) == 1;
        nx.oe   = ($countones(nx.val) % 2) == 0;
      end
    end
    return nx;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial forever begin
    @(posedge clk or posedge reset);
    for (int i = 0; i < N; i++) begin
      if (reset) m[i] = zero_state();
      else m[i] = model_next(m[i], i, start[i], abort[i], in_valid[i], in_bit[i]);
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        n_tests++;
        if ({busy[i], done[i], res[i], divisible[i], even[i], odd[i], ones_even[i]} !==
            {m[i].busy, m[i].done, m[i].res, m[i].dv, m[i].ev, m[i].od, m[i].oe}) begin
          n_fail++;
          $display("FAIL model_cmp inst%0d cyc%0d: got b%0b d%0b r%0d dv%0b e%0b o%0b oe%0b, required b%0b d%0b r%0d dv%0b e%0b o%0b oe%0b",
                   i, cyc, busy[i], done[i], res[i], divisible[i], even[i], odd[i], ones_even[i],
                   m[i].busy, m[i].done, m[i].res, m[i].dv, m[i].ev, m[i].od, m[i].oe);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d required <50000", cyc);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic pulse_start(input int i);
    @(negedge clk);
    start[i]    = 1'b1;
    abort[i]    = 1'b0;
    in_valid[i] = 1'b0;
  endtask

  // Deterministic gaps of 0..gapmax idle cycles before each bit.
  task automatic send_bits(input int i, input logic [63:0] bits, input int n, input int gapmax,
                           output int first_cyc);
    int g;
    first_cyc = 0;
    for (int k = n - 1; k >= 0; k--) begin
      g = (gapmax > 0) ? ((k * 7 + 3) % (gapmax + 1)) : 0;
      repeat (g) begin
        @(negedge clk);
        start[i] = 1'b0; in_valid[i] = 1'b0;
      end
      @(negedge clk);
      start[i] = 1'b0; in_valid[i] = 1'b1; in_bit[i] = bits[k];
      if (k == n - 1) first_cyc = cyc;
    end
  endtask

  task automatic send_frame(input int i, input logic [63:0] bits, input int n, input int gapmax,
                            input logic start_after, output int first_cyc);
    send_bits(i, bits, n, gapmax, first_cyc);
    @(negedge clk);
    in_valid[i] = 1'b0; in_bit[i] = 1'b0; start[i] = start_after;
    check($sformatf("done_after_last_bit_i%0d", i), 64'(done[i]), 64'd1);
  endtask

  initial begin
    int   f;
    logic saw_done;
    for (int i = 0; i < N; i++) begin
      start[i] = 1'b0; abort[i] = 1'b0; in_valid[i] = 1'b0; in_bit[i] = 1'b0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({busy[0], done[0], res[0], divisible[0], even[0], odd[0],
                                ones_even[0]}), 64'd0);
    reset  = 1'b0;
    chk_en = 1'b1;

    // 00001100 = 12, MOD 3, no gaps
    pulse_start(0);
    send_frame(0, 64'b00001100, 8, 0, 1'b0, f);
    check("t12_latency", 64'(cyc - f), 64'd8);
    check("t12_residue", 64'(res[0]), 64'd0);
    check("t12_div_even_odd_oe", 64'({divisible[0], even[0], odd[0], ones_even[0]}), 64'b1101);

    // 10110101 = 181 with gaps
    pulse_start(0);
    send_frame(0, 64'b10110101, 8, 3, 1'b0, f);
    check("t181_residue", 64'(res[0]), 64'd1);
    check("t181_div_even_odd_oe", 64'({divisible[0], even[0], odd[0], ones_even[0]}), 64'b0010);

    // Abort after 4 of 8 bits
    pulse_start(0);
    send_bits(0, 64'b0110, 4, 0, f);
    @(negedge clk);
    in_valid[0] = 1'b0; abort[0] = 1'b1;
    check("abort_busy_before", 64'(busy[0]), 64'd1);
    @(negedge clk);
    abort[0] = 1'b0;
    check("abort_busy_falls", 64'(busy[0]), 64'd0);
    check("abort_keeps_residue", 64'(res[0]), 64'd1);
    check("abort_keeps_odd", 64'(odd[0]), 64'd1);
    saw_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      saw_done = saw_done | done[0];
    end
    check("abort_no_done", 64'(saw_done), 64'd0);

    // Start mid-frame drops the bit sampled with it; 00000011 = 3
    pulse_start(0);
    send_bits(0, 64'b101, 3, 0, f);
    @(negedge clk);
    start[0] = 1'b1; in_valid[0] = 1'b1; in_bit[0] = 1'b1;
    send_frame(0, 64'b00000011, 8, 0, 1'b0, f);
    check("restart_residue", 64'(res[0]), 64'd0);
    check("restart_odd_oe", 64'({odd[0], ones_even[0]}), 64'b11);

    // Asynchronous reset mid-frame
    pulse_start(0);
    send_bits(0, 64'b1010, 4, 0, f);
    @(negedge clk);
    in_valid[0] = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("reset_async_outputs", 64'({busy[0], done[0], res[0], divisible[0], even[0], odd[0],
                                      ones_even[0]}), 64'd0);
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    start[0] = 1'b1;
    @(negedge clk);
    check("start_on_first_edge_after_reset", 64'({busy[0], done[0]}), 64'b10);
    send_frame(0, 64'hFF, 8, 0, 1'b0, f);
    check("t255_residue", 64'(res[0]), 64'd0);
    check("t255_oe_odd", 64'({ones_even[0], odd[0]}), 64'b11);

    // modulus-5 instance with 4-bit frames: 1010 then back-to-back 0111
    pulse_start(1);
    send_frame(1, 64'b1010, 4, 0, 1'b1, f);
    check("m5_first_residue", 64'(res[1]), 64'd0);
    check("m5_first_divisible", 64'(divisible[1]), 64'd1);
    @(negedge clk);
    start[1] = 1'b0; in_valid[1] = 1'b1; in_bit[1] = 1'b0;
    check("m5_no_idle_between", 64'(busy[1]), 64'd1);
    send_frame(1, 64'b111, 3, 0, 1'b0, f);
    check("m5_second_residue", 64'(res[1]), 64'd2);
    check("m5_second_div_odd", 64'({divisible[1], odd[1]}), 64'b01);

    // modulus-2 sweep over all 8-bit values, back to back
    pulse_start(2);
    for (int v = 0; v < 256; v++) begin
      send_frame(2, 64'(v), 8, 0, (v != 255), f);
      check($sformatf("m2_residue_v%0d", v), 64'(res[2]), 64'(v % 2));
      check($sformatf("m2_div_eq_even_v%0d", v), 64'(divisible[2]), 64'(even[2]));
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
